accu_param_top: RTL and testbench
=================================

// Module: accu_param_top
// PURPOSE
//  Parametrised successor to the single-mode accumulator top. Steps one operation per
//  press of the debounced 'next' button. Each step applies the operand 'in' to the
//  accumulator using a selectable mode: add, sub, max or clear. Adds selectable
//  saturation, a sticky overflow flag, an operation counter and an auto-hold after
//  MAX_OPS steps. Sits between board switches/button and the 7-seg/LED display logic.
// PARAMETERS
//  WIDTH    8  accumulator, operand and out width (bits), unsigned
//  MAX_OPS  4  steps (including initial load) before entering HOLD; >=2
//  SAT      1  1: clamp to 0 / 2^WIDTH-1 on under/overflow; 0: wrap modulo 2^WIDTH
// PORTS
//  clk            in   1                     system clock, all logic on rising edge
//  reset          in   1                     synchronous, active-high
//  next           in   1                     step button (already debounced, level)
//  mode           in   2                     00 add, 01 sub, 10 max, 11 clear
//  in             in   WIDTH                 operand
//  out            out  WIDTH                 accumulator value (registered)
//  state_display  out  2                     FSM state code: IDLE=0, ACC=1, HOLD=2
//  ovf            out  1                     sticky over/underflow flag
//  count          out  $clog2(MAX_OPS+1)     steps performed since load
// BEHAVIOUR
//  - Reset (wins over everything): out=0, state=IDLE, ovf=0, count=0, next_q=1.
//    next_q=1 means a button held through reset release does NOT trigger a step.
//  - Edge detect: next_q <= next every cycle; step = next & ~next_q.
//    Exactly one step per press, regardless of hold length.
//  - Latency: a step commits on the edge where step=1; out/count/ovf/state are valid
//    right after that edge. No combinational path from inputs to outputs.
//  - IDLE: on step: acc<=in, count<=1, ovf<=0, -> ACC. mode is ignored in IDLE.
//  - ACC: on step, apply mode with a WIDTH+1-bit intermediate:
//      add: sum=acc+in; carry -> ovf<=1, acc<=SAT ? all-ones : sum[WIDTH-1:0]
//      sub: in>acc -> ovf<=1, acc<=SAT ? 0 : (acc-in) mod 2^WIDTH
//      max: acc<=max(acc,in); ovf unchanged
//      clear: acc<=0, count<=0, ovf<=0; stay ACC (clear is not counted)
//    For non-clear modes: count<=count+1. If the new count == MAX_OPS -> HOLD.
//  - HOLD: out and ovf frozen; in and mode ignored. On step: acc<=0, count<=0,
//    ovf<=0 (ovf stays set in HOLD until this step) -> IDLE.
//  - ovf is sticky: once set it stays set until reset, clear, or a fresh load.
//  - State code 3 is illegal: recover to IDLE with out=0 on the next edge.
//  - Without a step, all registers hold (except next_q).
// TESTING (WIDTH=8, MAX_OPS=4, SAT=1 unless stated)
//  1 reset 2 cycles -> out=00, state=0, ovf=0, count=0.
//  2 in=05 press -> state=1, out=05, count=1. mode=00, in=03 press -> out=08, count=2.
//    Then hold next high 10 cycles -> out stays 08, count stays 2 (single step).
//  3 load F0, add 20 -> out=FF, ovf=1. Same with SAT=0 -> out=10, ovf=1.
//    Next: add 01 with SAT=1 -> out=FF, ovf still 1.
//  4 load 03, sub 05 -> out=00, ovf=1. Then mode=11 press -> out=00, ovf=0, count=0,
//    state=1. Then load 09, max 04 -> out=09; max 0C -> out=0C.
//  5 load 01 + 3 adds of 01 -> out=04, count=4, state=2. In HOLD, press with in=50
//    -> state=0, out=00, count=0.
//  6 reset mid-ACC (out=08) while next=1 -> out=00, state=0 next edge. Release reset
//    with next still 1 -> no step. Drop next, press with in=07 -> out=07, state=1.

Source files
------------

// File: rtl/accu_param_top.sv
// Stepped accumulator: one add/sub/max/clear operation per 'next' press, with optional
// saturation, sticky overflow, an operation counter and auto-hold after MAX_OPS steps.
module accu_param_top #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MAX_OPS = 4,
    parameter bit          SAT     = 1'b1,
    localparam int unsigned CW     = $clog2(MAX_OPS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             next,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [1:0]       state_display,
    output logic             ovf,
    output logic [CW-1:0]    count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        M_ADD   = 2'b00,
        M_SUB   = 2'b01,
        M_MAX   = 2'b10,
        M_CLEAR = 2'b11
    } mode_t;

    state_t          state;
    logic            next_q;
    logic            step;
    logic [WIDTH:0]  sum;
    logic [WIDTH:0]  diff;
    logic [CW-1:0]   count_inc;
    mode_t           op;

    assign step      = next & ~next_q;
    assign sum       = {1'b0, out} + {1'b0, in};
    assign diff      = {1'b0, out} - {1'b0, in};
    assign count_inc = count + CW'(1);
    assign op        = mode_t'(mode);

    assign state_display = state;

    always_ff @(posedge clk) begin
        next_q <= next;
        if (reset) begin
            // next_q starts high so a button held through reset release is not a step
            next_q <= 1'b1;
            state  <= IDLE;
            out    <= '0;
            ovf    <= 1'b0;
            count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (step) begin
                        out   <= in;
                        count <= CW'(1);
                        ovf   <= 1'b0;
                        state <= ACC;
                    end
                end
                ACC: begin
                    if (step) begin
                        case (op)
                            M_ADD: begin
                                if (sum[WIDTH]) begin
                                    ovf <= 1'b1;
                                    out <= SAT ? '1 : sum[WIDTH-1:0];
                                end else begin
                                    out <= sum[WIDTH-1:0];
                                end
                            end
                            M_SUB: begin
                                if (diff[WIDTH]) begin
                                    ovf <= 1'b1;
                                    out <= SAT ? '0 : diff[WIDTH-1:0];
                                end else begin
                                    out <= diff[WIDTH-1:0];
                                end
                            end
                            M_MAX: begin
                                out <= (in > out) ? in : out;
                            end
                            default: begin
                                out <= '0;
                                ovf <= 1'b0;
                            end
                        endcase
                        // clear resets the counter and is not itself counted
                        if (op == M_CLEAR) begin
                            count <= '0;
                        end else begin
                            count <= count_inc;
                            if (count_inc == CW'(MAX_OPS))
                                state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (step) begin
                        out   <= '0;
                        count <= '0;
                        ovf   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    out   <= '0;
                    count <= '0;
                    ovf   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accu_param_top.sv
// Directed bench for accu_param_top: a saturating and a wrapping instance share stimulus,
// a cycle table covers the step modes and hand-written sequences cover held/reset corners.
module tb_accu_param_top;

    logic       clk = 1'b0;
    logic       reset;
    logic       next;
    logic [1:0] mode;
    logic [7:0] in_v;
    logic [7:0] out_s, out_w;
    logic [1:0] st_s, st_w;
    logic       ovf_s, ovf_w;
    logic [2:0] cnt_s, cnt_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    accu_param_top #(.WIDTH(8), .MAX_OPS(4), .SAT(1'b1)) dut_s (
        .clk(clk), .reset(reset), .next(next), .mode(mode), .in(in_v),
        .out(out_s), .state_display(st_s), .ovf(ovf_s), .count(cnt_s)
    );

    accu_param_top #(.WIDTH(8), .MAX_OPS(4), .SAT(1'b0)) dut_w (
        .clk(clk), .reset(reset), .next(next), .mode(mode), .in(in_v),
        .out(out_w), .state_display(st_w), .ovf(ovf_w), .count(cnt_w)
    );

    typedef struct {
        logic       rst;
        logic       nxt;
        logic [1:0] mode;
        logic [7:0] din;
        logic [7:0] exp_out;
        logic [7:0] exp_out_w;
        logic [1:0] exp_st;
        logic       exp_ovf;
        logic [2:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic r, input logic n, input logic [1:0] m, input logic [7:0] d,
                           input logic [7:0] eo, input logic [7:0] ew, input logic [1:0] es,
                           input logic eov, input logic [2:0] ec);
        vec_t v;
        v.rst = r; v.nxt = n; v.mode = m; v.din = d;
        v.exp_out = eo; v.exp_out_w = ew; v.exp_st = es; v.exp_ovf = eov; v.exp_cnt = ec;
        vecs.push_back(v);
    endtask

    task automatic cycle(input logic r, input logic n, input logic [1:0] m, input logic [7:0] d);
        reset = r; next = n; mode = m; in_v = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp_v);
        end
    endtask

    task automatic expect_all(input string tag, input int idx, input logic [7:0] eo, input logic [7:0] ew,
                              input logic [1:0] es, input logic eov, input logic [2:0] ec);
        chk({tag, "/out_sat"},   idx, out_s, eo);
        chk({tag, "/out_wrap"},  idx, out_w, ew);
        chk({tag, "/state_sat"}, idx, {6'd0, st_s}, {6'd0, es});
        chk({tag, "/state_wrap"},idx, {6'd0, st_w}, {6'd0, es});
        chk({tag, "/ovf_sat"},   idx, {7'd0, ovf_s}, {7'd0, eov});
        chk({tag, "/ovf_wrap"},  idx, {7'd0, ovf_w}, {7'd0, eov});
        chk({tag, "/cnt_sat"},   idx, {5'd0, cnt_s}, {5'd0, ec});
        chk({tag, "/cnt_wrap"},  idx, {5'd0, cnt_w}, {5'd0, ec});
    endtask

    initial begin
        // reset state
        add_vec(1, 0, 2'd0, 8'h00, 8'h00, 8'h00, 2'd0, 0, 3'd0);
        add_vec(1, 0, 2'd0, 8'h00, 8'h00, 8'h00, 2'd0, 0, 3'd0);
        add_vec(0, 0, 2'd0, 8'h00, 8'h00, 8'h00, 2'd0, 0, 3'd0);
        // load 05, add 03
        add_vec(0, 1, 2'd0, 8'h05, 8'h05, 8'h05, 2'd1, 0, 3'd1);
        add_vec(0, 0, 2'd0, 8'h03, 8'h05, 8'h05, 2'd1, 0, 3'd1);
        add_vec(0, 1, 2'd0, 8'h03, 8'h08, 8'h08, 2'd1, 0, 3'd2);
        add_vec(0, 0, 2'd0, 8'h03, 8'h08, 8'h08, 2'd1, 0, 3'd2);
        // add overflow: saturate vs wrap, then run into HOLD with ovf frozen
        add_vec(1, 0, 2'd0, 8'h00, 8'h00, 8'h00, 2'd0, 0, 3'd0);
        add_vec(0, 0, 2'd0, 8'h00, 8'h00, 8'h00, 2'd0, 0, 3'd0);
        add_vec(0, 1, 2'd1, 8'hF0, 8'hF0, 8'hF0, 2'd1, 0, 3'd1);
        add_vec(0, 0, 2'd0, 8'h20, 8'hF0, 8'hF0, 2'd1, 0, 3'd1);
        add_vec(0, 1, 2'd0, 8'h20, 8'hFF, 8'h10, 2'd1, 1, 3'd2);
        add_vec(0, 0, 2'd0, 8'h01, 8'hFF, 8'h10, 2'd1, 1, 3'd2);
        add_vec(0, 1, 2'd0, 8'h01, 8'hFF, 8'h11, 2'd1, 1, 3'd3);
        add_vec(0, 0, 2'd0, 8'h01, 8'hFF, 8'h11, 2'd1, 1, 3'd3);
        add_vec(0, 1, 2'd0, 8'h01, 8'hFF, 8'h12, 2'd2, 1, 3'd4);
        add_vec(0, 0, 2'd1, 8'hAA, 8'hFF, 8'h12, 2'd2, 1, 3'd4);
        add_vec(0, 1, 2'd1, 8'hAA, 8'h00, 8'h00, 2'd0, 0, 3'd0);
        add_vec(0, 0, 2'd0, 8'h00, 8'h00, 8'h00, 2'd0, 0, 3'd0);
        // sub underflow, clear, then max
        add_vec(0, 1, 2'd1, 8'h03, 8'h03, 8'h03, 2'd1, 0, 3'd1);
        add_vec(0, 0, 2'd1, 8'h05, 8'h03, 8'h03, 2'd1, 0, 3'd1);
        add_vec(0, 1, 2'd1, 8'h05, 8'h00, 8'hFE, 2'd1, 1, 3'd2);
        add_vec(0, 0, 2'd3, 8'h00, 8'h00, 8'hFE, 2'd1, 1, 3'd2);
        add_vec(0, 1, 2'd3, 8'h00, 8'h00, 8'h00, 2'd1, 0, 3'd0);
        add_vec(0, 0, 2'd0, 8'h09, 8'h00, 8'h00, 2'd1, 0, 3'd0);
        add_vec(0, 1, 2'd0, 8'h09, 8'h09, 8'h09, 2'd1, 0, 3'd1);
        add_vec(0, 0, 2'd2, 8'h04, 8'h09, 8'h09, 2'd1, 0, 3'd1);
        add_vec(0, 1, 2'd2, 8'h04, 8'h09, 8'h09, 2'd1, 0, 3'd2);
        add_vec(0, 0, 2'd2, 8'h0C, 8'h09, 8'h09, 2'd1, 0, 3'd2);
        add_vec(0, 1, 2'd2, 8'h0C, 8'h0C, 8'h0C, 2'd1, 0, 3'd3);
        // MAX_OPS steps -> HOLD, frozen in HOLD, press -> IDLE, fresh load
        add_vec(1, 0, 2'd0, 8'h00, 8'h00, 8'h00, 2'd0, 0, 3'd0);
        add_vec(0, 0, 2'd0, 8'h00, 8'h00, 8'h00, 2'd0, 0, 3'd0);
        add_vec(0, 1, 2'd0, 8'h01, 8'h01, 8'h01, 2'd1, 0, 3'd1);
        add_vec(0, 0, 2'd0, 8'h01, 8'h01, 8'h01, 2'd1, 0, 3'd1);
        add_vec(0, 1, 2'd0, 8'h01, 8'h02, 8'h02, 2'd1, 0, 3'd2);
        add_vec(0, 0, 2'd0, 8'h01, 8'h02, 8'h02, 2'd1, 0, 3'd2);
        add_vec(0, 1, 2'd0, 8'h01, 8'h03, 8'h03, 2'd1, 0, 3'd3);
        add_vec(0, 0, 2'd0, 8'h01, 8'h03, 8'h03, 2'd1, 0, 3'd3);
        add_vec(0, 1, 2'd0, 8'h01, 8'h04, 8'h04, 2'd2, 0, 3'd4);
        add_vec(0, 0, 2'd0, 8'h50, 8'h04, 8'h04, 2'd2, 0, 3'd4);
        add_vec(0, 1, 2'd1, 8'h50, 8'h00, 8'h00, 2'd0, 0, 3'd0);
        add_vec(0, 0, 2'd0, 8'h07, 8'h00, 8'h00, 2'd0, 0, 3'd0);
        add_vec(0, 1, 2'd3, 8'h07, 8'h07, 8'h07, 2'd1, 0, 3'd1);

        foreach (vecs[i]) begin
            cycle(vecs[i].rst, vecs[i].nxt, vecs[i].mode, vecs[i].din);
            expect_all("table", i, vecs[i].exp_out, vecs[i].exp_out_w, vecs[i].exp_st,
                       vecs[i].exp_ovf, vecs[i].exp_cnt);
        end

        // held button gives exactly one step
        cycle(1, 0, 2'd0, 8'h00);
        cycle(0, 0, 2'd0, 8'h00);
        cycle(0, 1, 2'd0, 8'h05);
        expect_all("hold_load", 0, 8'h05, 8'h05, 2'd1, 0, 3'd1);
        cycle(0, 0, 2'd0, 8'h03);
        cycle(0, 1, 2'd0, 8'h03);
        expect_all("hold_add", 0, 8'h08, 8'h08, 2'd1, 0, 3'd2);
        for (int k = 0; k < 10; k++) begin
            cycle(0, 1, 2'd0, 8'h03);
            expect_all("held", k, 8'h08, 8'h08, 2'd1, 0, 3'd2);
        end

        // reset while button held, release with button still held
        cycle(1, 1, 2'd0, 8'h03);
        expect_all("rst_held", 0, 8'h00, 8'h00, 2'd0, 0, 3'd0);
        cycle(0, 1, 2'd0, 8'h07);
        expect_all("rel_held", 0, 8'h00, 8'h00, 2'd0, 0, 3'd0);
        cycle(0, 1, 2'd0, 8'h07);
        expect_all("rel_held", 1, 8'h00, 8'h00, 2'd0, 0, 3'd0);
        cycle(0, 0, 2'd0, 8'h07);
        expect_all("drop", 0, 8'h00, 8'h00, 2'd0, 0, 3'd0);
        cycle(0, 1, 2'd0, 8'h07);
        expect_all("repress", 0, 8'h07, 8'h07, 2'd1, 0, 3'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
